// File: rtl/seq11011_rr_scheduler.sv
// Round-robin time-shared overlapping "11011" Moore detector for CHANNELS serial streams.
// One buffered bit per cycle is granted to the shared core; per-channel saturating match counters.
//
// state | meaning
// S0    | idle, no prefix seen
// S1    | seen "1"
// S2    | seen "11"
// S3    | seen "110"
// S4    | seen "1101"
// S5    | seen "11011" (match)
module seq11011_rr_scheduler #(
  parameter int CHANNELS = 4,
  parameter int CH_W     = 2,
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] in_valid,
  input  logic [CHANNELS-1:0] in_bit,
  output logic [CHANNELS-1:0] in_ready,
  input  logic [CHANNELS-1:0] chan_clear,
  output logic                det_valid,
  output logic [CH_W-1:0]     det_ch,
  output logic                det_match,
  input  logic [CH_W-1:0]     rd_ch,
  output logic [CNT_W-1:0]    rd_count
);

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4,
    S5 = 3'd5
  } state_t;

  state_t              slot     [CHANNELS];
  logic [CNT_W-1:0]    count    [CHANNELS];
  logic [CHANNELS-1:0] buf_full;
  logic [CHANNELS-1:0] buf_bit;
  logic [CH_W-1:0]     ptr;

  logic                gnt_found;
  logic                gnt;
  logic [CH_W-1:0]     gnt_ch;
  state_t              gnt_nxt;

  function automatic state_t next_state(input state_t s, input logic b);
    case (s)
      S0:      next_state = b ? S1 : S0;
      S1:      next_state = b ? S2 : S0;
      S2:      next_state = b ? S2 : S3;
      S3:      next_state = b ? S4 : S0;
      S4:      next_state = b ? S5 : S0;
      S5:      next_state = b ? S2 : S3;
      default: next_state = S0;
    endcase
  endfunction

  assign in_ready = ~buf_full;

  // first full buffer at or after ptr, wrapping
  always_comb begin
    gnt_found = 1'b0;
    gnt_ch    = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      int idx;
      idx = int'(ptr) + k;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      if (!gnt_found && buf_full[idx]) begin
        gnt_found = 1'b1;
        gnt_ch    = CH_W'(idx);
      end
    end
    gnt     = gnt_found & ~chan_clear[gnt_ch];
    gnt_nxt = next_state(slot[gnt_ch], buf_bit[gnt_ch]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        slot[i]  <= S0;
        count[i] <= '0;
      end
      buf_full  <= '0;
      buf_bit   <= '0;
      ptr       <= '0;
      det_valid <= 1'b0;
      det_ch    <= '0;
      det_match <= 1'b0;
      rd_count  <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (chan_clear[i]) begin
          // a bit accepted into an empty buffer survives the clear
          slot[i]     <= S0;
          count[i]    <= '0;
          buf_full[i] <= in_valid[i] & ~buf_full[i];
          if (in_valid[i] && !buf_full[i]) buf_bit[i] <= in_bit[i];
        end else if (gnt && gnt_ch == CH_W'(i)) begin
          slot[i]     <= gnt_nxt;
          buf_full[i] <= 1'b0;
          if (gnt_nxt == S5 && count[i] != {CNT_W{1'b1}}) count[i] <= count[i] + CNT_W'(1);
        end else if (in_valid[i] && !buf_full[i]) begin
          buf_full[i] <= 1'b1;
          buf_bit[i]  <= in_bit[i];
        end
      end

      if (gnt) begin
        ptr       <= (gnt_ch == CH_W'(CHANNELS - 1)) ? '0 : gnt_ch + CH_W'(1);
        det_valid <= 1'b1;
        det_ch    <= gnt_ch;
        det_match <= (gnt_nxt == S5);
      end else begin
        det_valid <= 1'b0;
      end

      rd_count <= (int'(rd_ch) < CHANNELS) ? count[rd_ch] : '0;
    end
  end

endmodule

// File: tb/tb_seq11011_rr_scheduler.sv
// Directed bench for seq11011_rr_scheduler: hand-computed match positions, grant order,
// clear/reset corner cases and counter saturation.
module tb_seq11011_rr_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] in_valid = '0;
  logic [3:0] in_bit = '0;
  logic [3:0] in_ready;
  logic [3:0] chan_clear = '0;
  logic       det_valid;
  logic [1:0] det_ch;
  logic       det_match;
  logic [1:0] rd_ch = '0;
  logic [7:0] rd_count;

  int n_vec = 0;
  int n_err = 0;

  seq11011_rr_scheduler #(.CHANNELS(4), .CH_W(2), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_bit     (in_bit),
    .in_ready   (in_ready),
    .chan_clear (chan_clear),
    .det_valid  (det_valid),
    .det_ch     (det_ch),
    .det_match  (det_match),
    .rd_ch      (rd_ch),
    .rd_count   (rd_count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // ends at a negedge with reset just released
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = '0;
    chan_clear = '0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // one bit on one channel, 2 cycles per bit; det is sampled two cycles after handshake
  task automatic push(input int ch, input logic b, input logic exp_m, input bit chk);
    if (chk) check_val("push_ready", 32'(in_ready[ch]), 32'd1);
    in_valid[ch] = 1'b1;
    in_bit[ch] = b;
    @(posedge clk);
    @(negedge clk);
    in_valid[ch] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    if (chk) begin
      check_val("det_valid", 32'(det_valid), 32'd1);
      check_val("det_ch", 32'(det_ch), 32'(ch));
      check_val("det_match", 32'(det_match), 32'(exp_m));
    end
  endtask

  task automatic read_cnt(input int ch, input int exp);
    rd_ch = 2'(ch);
    @(posedge clk);
    @(negedge clk);
    check_val("rd_count", 32'(rd_count), 32'(exp));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] v8, e8;
    logic [4:0] pa, pb, pe;
    logic [6:0] v7, e7;

    // reset values
    do_reset();
    check_val("rst_ready", 32'(in_ready), 32'hF);
    check_val("rst_det_valid", 32'(det_valid), 32'd0);
    check_val("rst_det_ch", 32'(det_ch), 32'd0);
    check_val("rst_det_match", 32'(det_match), 32'd0);
    check_val("rst_rd_count", 32'(rd_count), 32'd0);

    // ch0 alone: 11011011 matches on bits 5 and 8
    v8 = 8'b11011011;
    e8 = 8'b00001001;
    for (int i = 0; i < 8; i++) push(0, v8[7-i], e8[7-i], 1'b1);
    read_cnt(0, 2);

    // all channels valid every cycle: det_ch 0,1,2,3,...
    do_reset();
    in_bit = '0;
    in_valid = 4'hF;
    @(posedge clk);
    @(negedge clk);
    check_val("rr_ready_c1", 32'(in_ready), 32'h0);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_val("rr_det_valid", 32'(det_valid), 32'd1);
      check_val("rr_det_ch", 32'(det_ch), 32'(i % 4));
    end
    in_valid = '0;

    // ch1 11011 and ch2 11101 interleaved
    do_reset();
    pa = 5'b11011;
    pb = 5'b11101;
    pe = 5'b00001;
    for (int i = 0; i < 5; i++) begin
      in_valid[1] = 1'b1; in_bit[1] = pa[4-i];
      in_valid[2] = 1'b1; in_bit[2] = pb[4-i];
      @(posedge clk);
      @(negedge clk);
      in_valid = '0;
      @(posedge clk);
      @(negedge clk);
      check_val("il_det_ch1", 32'(det_ch), 32'd1);
      check_val("il_match1", 32'(det_match), 32'(pe[4-i]));
      @(posedge clk);
      @(negedge clk);
      check_val("il_det_ch2", 32'(det_ch), 32'd2);
      check_val("il_match2", 32'(det_match), 32'd0);
    end
    read_cnt(1, 1);
    read_cnt(2, 0);

    // ch3 saturation: 300 matches clamp at 255
    do_reset();
    for (int r = 0; r < 300; r++)
      for (int j = 0; j < 5; j++) push(3, pa[4-j], 1'b0, 1'b0);
    read_cnt(3, 255);
    for (int j = 0; j < 5; j++) push(3, pa[4-j], pe[4-j], 1'b1);
    read_cnt(3, 255);

    // clear in the grant cycle of ch0 at S4 with a 1 buffered
    do_reset();
    v7 = 7'b1101101;
    e7 = 7'b0000100;
    for (int i = 0; i < 7; i++) push(0, v7[6-i], e7[6-i], 1'b1);
    read_cnt(0, 1);
    in_valid[0] = 1'b1; in_bit[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid[0] = 1'b0;
    chan_clear[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chan_clear[0] = 1'b0;
    check_val("clr_no_det", 32'(det_valid), 32'd0);
    read_cnt(0, 0);
    for (int i = 0; i < 5; i++) push(0, pa[4-i], pe[4-i], 1'b1);
    read_cnt(0, 1);

    // reset mid-stream with all buffers full
    do_reset();
    for (int i = 0; i < 7; i++) push(1, v7[6-i], e7[6-i], 1'b1);
    read_cnt(1, 1);
    in_valid = 4'hF;
    in_bit = 4'hF;
    @(posedge clk);
    @(negedge clk);
    in_valid = '0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_val("mid_rst_ready", 32'(in_ready), 32'hF);
    check_val("mid_rst_det_valid", 32'(det_valid), 32'd0);
    check_val("mid_rst_rd_count", 32'(rd_count), 32'd0);
    for (int i = 0; i < 5; i++) push(1, pa[4-i], pe[4-i], 1'b1);
    read_cnt(1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
